// File: rtl/iiitb_pwm_pkg.sv
// Shared defaults, width helpers and types for the button-controlled PWM generator.
package iiitb_pwm_pkg;

    localparam int PWM_PERIOD_DEF   = 10;
    localparam int DUTY_INIT_DEF    = 5;
    localparam int DEBOUNCE_DIV_DEF = 4;

    // Duty must represent 0..period inclusive, hence the +1.
    function automatic int duty_width(input int period);
        return $clog2(period + 1);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DUTY_W = duty_width(PWM_PERIOD_DEF);

    typedef enum logic [1:0] {
        DUTY_HOLD = 2'd0,
        DUTY_INC  = 2'd1,
        DUTY_DEC  = 2'd2
    } duty_op_e;

endpackage

// File: rtl/iiitb_pwm_debounce.sv
// Tick-sampled two-flop button chain with rising-edge press detection.
module iiitb_pwm_debounce
    import iiitb_pwm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic button_i,
    output logic press_o
);

    logic q1_q, q1_d;
    logic q2_q, q2_d;

    always_comb begin
        q1_d = q1_q;
        q2_d = q2_q;
        if (tick_i) begin
            q1_d = button_i;
            q2_d = q1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    // Gating with the tick keeps the pulse exactly one clock wide.
    assign press_o = tick_i & q1_q & ~q2_q;

endmodule

// File: rtl/iiitb_pwm_gen.sv
// PWM generator whose duty is stepped up/down by two debounced push buttons.
module iiitb_pwm_gen
    import iiitb_pwm_pkg::*;
#(
    parameter int PWM_PERIOD   = PWM_PERIOD_DEF,
    parameter int DUTY_INIT    = DUTY_INIT_DEF,
    parameter int DEBOUNCE_DIV = DEBOUNCE_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic PWM_OUT
);

    localparam int DW = duty_width(PWM_PERIOD);
    localparam int TW = cnt_width(DEBOUNCE_DIV);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          inc_press, dec_press;
    duty_op_e      duty_op;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          pwm_q, pwm_d;

    always_comb begin
        tick       = (tick_cnt_q == TW'(DEBOUNCE_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    iiitb_pwm_debounce u_db_inc (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick),
        .button_i (increase_duty),
        .press_o  (inc_press)
    );

    iiitb_pwm_debounce u_db_dec (
        .clk      (clk),
        .reset    (reset),
        .tick_i   (tick),
        .button_i (decrease_duty),
        .press_o  (dec_press)
    );

    // Simultaneous presses cancel out.
    always_comb begin
        duty_op = DUTY_HOLD;
        if (inc_press && !dec_press) begin
            duty_op = DUTY_INC;
        end else if (dec_press && !inc_press) begin
            duty_op = DUTY_DEC;
        end
    end

    always_comb begin
        duty_d = duty_q;
        unique case (duty_op)
            DUTY_INC: begin
                if (duty_q != DW'(PWM_PERIOD)) begin
                    duty_d = duty_q + DW'(1);
                end
            end
            DUTY_DEC: begin
                if (duty_q != '0) begin
                    duty_d = duty_q - DW'(1);
                end
            end
            default: duty_d = duty_q;
        endcase
    end

    always_comb begin
        cnt_d = (cnt_q == DW'(PWM_PERIOD - 1)) ? '0 : cnt_q + DW'(1);
        pwm_d = (cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            duty_q     <= DW'(DUTY_INIT);
            cnt_q      <= '0;
            pwm_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            duty_q     <= duty_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_iiitb_pwm_gen.sv
// Directed bench for iiitb_pwm_gen: duty inferred from high cycles per period.
module tb_iiitb_pwm_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic increase_duty = 1'b0;
    logic decrease_duty = 1'b0;
    logic PWM_OUT;

    int total = 0;
    int bad = 0;

    iiitb_pwm_gen dut (
        .clk           (clk),
        .reset         (reset),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .PWM_OUT       (PWM_OUT)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic inc, input logic dec);
        increase_duty = inc;
        decrease_duty = dec;
        repeat (10) step();
        increase_duty = 1'b0;
        decrease_duty = 1'b0;
        repeat (10) step();
    endtask

    task automatic measure(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (PWM_OUT === 1'b1) highs++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic exp;
        reset = 1'b1;
        step();
        total++;
        if (PWM_OUT !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got=%b want=0", PWM_OUT);
        end
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp = (((k - 1) % 10) < 5);
            total++;
            if (PWM_OUT !== exp) begin
                bad++;
                $display("FAIL reset_wave k=%0d got=%b want=%b", k, PWM_OUT, exp);
            end
        end
    endtask

    task automatic test_increase();
        int exp_tab[5] = '{6, 7, 8, 9, 10};
        int h;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0);
            measure(10, h);
            total++;
            if (h !== exp_tab[i]) begin
                bad++;
                $display("FAIL inc_%0d got=%0d want=%0d", i, h, exp_tab[i]);
            end
        end
        measure(20, h);
        total++;
        if (h !== 20) begin
            bad++;
            $display("FAIL full_high got=%0d want=20", h);
        end
    endtask

    task automatic test_saturate();
        int h;
        for (int i = 0; i < 2; i++) begin
            press(1'b1, 1'b0);
            measure(10, h);
            total++;
            if (h !== 10) begin
                bad++;
                $display("FAIL sat_high_%0d got=%0d want=10", i, h);
            end
        end
        for (int i = 0; i < 11; i++) begin
            press(1'b0, 1'b1);
            measure(10, h);
            total++;
            if (h !== ((i < 10) ? 9 - i : 0)) begin
                bad++;
                $display("FAIL dec_%0d got=%0d want=%0d", i, h,
                         (i < 10) ? 9 - i : 0);
            end
        end
        measure(20, h);
        total++;
        if (h !== 0) begin
            bad++;
            $display("FAIL full_low got=%0d want=0", h);
        end
    endtask

    task automatic test_hold();
        int h;
        apply_reset();
        increase_duty = 1'b1;
        repeat (100) step();
        measure(10, h);
        total++;
        if (h !== 6) begin
            bad++;
            $display("FAIL hold_during got=%0d want=6", h);
        end
        increase_duty = 1'b0;
        repeat (10) step();
        measure(10, h);
        total++;
        if (h !== 6) begin
            bad++;
            $display("FAIL hold_after got=%0d want=6", h);
        end
    endtask

    task automatic test_simultaneous();
        int h;
        press(1'b1, 1'b1);
        measure(10, h);
        total++;
        if (h !== 6) begin
            bad++;
            $display("FAIL both_press got=%0d want=6", h);
        end
    endtask

    task automatic test_reset_mid();
        int h;
        logic exp;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        measure(10, h);
        total++;
        if (h !== 8) begin
            bad++;
            $display("FAIL pre_reset got=%0d want=8", h);
        end
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (PWM_OUT !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_out got=%b want=0", PWM_OUT);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = (((k - 1) % 10) < 5);
            total++;
            if (PWM_OUT !== exp) begin
                bad++;
                $display("FAIL mid_reset_wave k=%0d got=%b want=%b",
                         k, PWM_OUT, exp);
            end
        end
    endtask

    task automatic test_held_through_reset();
        int h;
        increase_duty = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (20) step();
        increase_duty = 1'b0;
        repeat (10) step();
        measure(10, h);
        total++;
        if (h !== 6) begin
            bad++;
            $display("FAIL held_reset got=%0d want=6", h);
        end
    endtask

    initial begin
        test_reset();
        test_increase();
        test_saturate();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        test_held_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iiitb_pwm_gen.md
IIITB_PWM_GEN -- requirements
Module: iiitb_pwm_gen

Interface
REQ-001 Parameter PWM_PERIOD, default 10: PWM period in clock cycles; one duty step equals 10 %.
REQ-002 Parameter DUTY_INIT, default 5: duty value loaded at reset (50 %).
REQ-003 Parameter DEBOUNCE_DIV, default 4: clock cycles between debounce sample ticks (at least 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 increase_duty  input  1  raw button, active-high; each press raises duty by one step.
REQ-007 decrease_duty  input  1  raw button, active-high; each press lowers duty by one step.
REQ-008 PWM_OUT  output  1  registered PWM waveform.

Function
REQ-009 Tick generator SHALL count 0..DEBOUNCE_DIV-1, wrap to 0, and assert a one-cycle tick at the wrap.
REQ-010 On each tick, each button SHALL shift into a two-flop sample chain (q1 <= button, q2 <= q1).
REQ-011 A press pulse SHALL be one clock wide: tick AND q1 AND NOT q2, giving exactly one pulse per low-to-high transition.
REQ-012 A button held high for any length SHALL produce only one press pulse.
REQ-013 Duty register SHALL be wide enough for 0..PWM_PERIOD and SHALL update on the cycle after a press pulse.
REQ-014 An increase pulse SHALL add 1 to duty, saturating at PWM_PERIOD (100 %).
REQ-015 A decrease pulse SHALL subtract 1 from duty, saturating at 0.
REQ-016 If increase and decrease pulses occur in the same cycle, duty SHALL be unchanged.
REQ-017 Period counter SHALL count 0..PWM_PERIOD-1 every cycle and wrap to 0.
REQ-018 PWM_OUT SHALL be registered from (counter < duty), giving one cycle of latency.
REQ-019 Within each period PWM_OUT SHALL be high for exactly duty cycles: duty 0 gives constant low; duty PWM_PERIOD gives constant high.
REQ-020 A duty change SHALL take effect at the next counter comparison; the period counter SHALL NOT restart.

Reset
REQ-021 While reset is high at a clock edge, the following SHALL load:
- period counter = 0
- tick counter = 0
- all debounce flops = 0
- duty = DUTY_INIT
- PWM_OUT = 0
REQ-022 Reset asserted mid-period or mid-press SHALL override all other activity in that cycle.
REQ-023 After reset, a button already held high SHALL count as one new press once sampled.

Structure
REQ-024 A shared package iiitb_pwm_pkg SHALL hold PWM_PERIOD, DUTY_INIT, DEBOUNCE_DIV defaults and the duty width, computed as $clog2(PWM_PERIOD+1).
REQ-025 Debounce and edge detection SHALL be one sub-module, iiitb_pwm_debounce, instantiated once per button; it takes clk, reset, tick and the button, and outputs the press pulse.
REQ-026 The tick generator, duty register, period counter and output register SHALL live in the top module.

Verification
REQ-027 Reset, then run 30 cycles -> PWM_OUT high 5 of every 10 cycles; first output cycle after reset is low.
REQ-028 Five increase presses, each 10 cycles high and 10 cycles low -> duty 6,7,8,9,10; final PWM_OUT constant high.
REQ-029 At duty 10, two more increase presses -> duty stays 10; then 11 decrease presses -> duty 0, PWM_OUT constant low, no underflow.
REQ-030 Hold increase_duty high for 100 cycles from duty 5 -> duty 6 only; simultaneous increase and decrease press -> duty unchanged.
REQ-031 Assert reset for one cycle at duty 8 mid-period -> next cycle PWM_OUT = 0, duty 5, counter restarts at 0.
